// File: rtl/ase_emul_tx_arb_pkg.sv
// Shared types and helpers for the ASE PCIe SS TX stream arbiters.
package ase_emul_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } t_arb_state;

  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned MAX_CH_W = 3;

  // First set bit of valid[num_ch-1:0] at or after ptr, wrapping; 0 when none is set.
  function automatic logic [MAX_CH_W-1:0] rr_pick(input logic [MAX_CH-1:0]   valid,
                                                  input logic [MAX_CH_W-1:0] ptr,
                                                  input int unsigned         num_ch);
    logic [MAX_CH_W-1:0] pick;
    logic                found;
    logic [MAX_CH_W:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < int'(num_ch)) begin
        idx = {1'b0, ptr} + (MAX_CH_W + 1)'(i);
        if (idx >= (MAX_CH_W + 1)'(num_ch)) idx = idx - (MAX_CH_W + 1)'(num_ch);
        if (!found && valid[idx[MAX_CH_W-1:0]]) begin
          pick  = idx[MAX_CH_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ase_emul_axis_pipe_reg.sv
// Single-stage AXI-Stream register slice with full throughput (ready = empty or draining).
module ase_emul_axis_pipe_reg #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 10,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic              in_tlast,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic [USER_W-1:0] in_tuser,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              out_tlast,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic [USER_W-1:0] out_tuser
);

  localparam int unsigned PL_W = 1 + DATA_W + KEEP_W + USER_W;

  logic            valid_q, valid_d;
  logic [PL_W-1:0] payload_q, payload_d;
  logic            load;

  assign in_tready = !valid_q || out_tready;
  assign load      = in_tvalid && in_tready;

  always_comb begin
    valid_d   = in_tready ? in_tvalid : valid_q;
    payload_d = load ? {in_tlast, in_tdata, in_tkeep, in_tuser} : payload_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is only observed while valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign out_tvalid = valid_q;
  assign {out_tlast, out_tdata, out_tkeep, out_tuser} = payload_q;

endmodule

// File: rtl/ase_emul_pcie_ss_tx_wrr_arb.sv
// Packet-atomic weighted round-robin merge of NUM_CH PCIe SS TX streams.
// Define ASE_EMUL_TX_WRR_ARB_STATS_EN for per-channel packet counters and a starvation check.
module ase_emul_pcie_ss_tx_wrr_arb
  import ase_emul_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned USER_W   = 10,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned CH_W    = $clog2(NUM_CH),
  localparam int unsigned KEEP_W  = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*WEIGHT_W-1:0] weights,
  input  logic [NUM_CH-1:0]          in_tvalid,
  output logic [NUM_CH-1:0]          in_tready,
  input  logic [NUM_CH-1:0]          in_tlast,
  input  logic [NUM_CH*DATA_W-1:0]   in_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]   in_tkeep,
  input  logic [NUM_CH*USER_W-1:0]   in_tuser_vendor,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       out_tlast,
  output logic [DATA_W-1:0]          out_tdata,
  output logic [KEEP_W-1:0]          out_tkeep,
  output logic [USER_W-1:0]          out_tuser_vendor,
  output logic [CH_W-1:0]            cur_grant
`ifdef ASE_EMUL_TX_WRR_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]       pkt_count
`endif
);

  t_arb_state          state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] credit_base, weight_w;
  logic [CH_W-1:0]     winner, sel;
  logic                keep_owner, any_valid;
  logic                sel_act, sel_valid, beat_acc, pkt_done;
  logic                out_ready_int;

  assign any_valid  = |in_tvalid;
  assign keep_owner = (credit_q != '0) && in_tvalid[grant_q];
  assign winner     = keep_owner ? grant_q
                                 : CH_W'(rr_pick(MAX_CH'(in_tvalid), MAX_CH_W'(rr_ptr_q), NUM_CH));
  assign weight_w   = weights[winner*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    credit_base = credit_q;
    sel         = grant_q;
    sel_act     = 1'b0;
    sel_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          sel       = winner;
          sel_act   = 1'b1;
          sel_valid = 1'b1;
          grant_d   = winner;
          state_d   = BUSY;
          // Every grant that is not a credit continuation opens a new turn,
          // including a re-grant of the same channel after its credit ran out.
          if (!keep_owner) begin
            credit_base = (weight_w == '0) ? WEIGHT_W'(1) : weight_w;
            rr_ptr_d    = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
          end
        end
      end
      BUSY: begin
        sel_act   = 1'b1;
        sel_valid = in_tvalid[grant_q];
      end
      default: ;
    endcase

    beat_acc = sel_valid && out_ready_int && rst_n;
    pkt_done = beat_acc && in_tlast[sel];
    credit_d = credit_base;
    if (pkt_done) begin
      credit_d = (credit_base == '0) ? '0 : credit_base - 1'b1;
      state_d  = IDLE;
    end
  end

  // Ready is held low while reset is asserted, even though the FSM sits in IDLE.
  always_comb begin
    in_tready      = '0;
    in_tready[sel] = sel_act && out_ready_int && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
    end
  end

  assign cur_grant = grant_q;

  ase_emul_axis_pipe_reg #(
    .DATA_W (DATA_W),
    .USER_W (USER_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tvalid  (sel_valid),
    .in_tready  (out_ready_int),
    .in_tlast   (in_tlast[sel]),
    .in_tdata   (in_tdata[sel*DATA_W +: DATA_W]),
    .in_tkeep   (in_tkeep[sel*KEEP_W +: KEEP_W]),
    .in_tuser   (in_tuser_vendor[sel*USER_W +: USER_W]),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tuser  (out_tuser_vendor)
  );

`ifdef ASE_EMUL_TX_WRR_ARB_STATS_EN
  localparam int unsigned STARVE_LIMIT = NUM_CH * 16 * (2 ** WEIGHT_W);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stats
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] wait_q, wait_d;
    logic        owns;

    assign owns = sel_act && (sel == CH_W'(gi));

    // wait counts packet completions that pass by while this channel is left requesting.
    always_comb begin
      cnt_d  = cnt_q + ((pkt_done && owns) ? 32'd1 : 32'd0);
      wait_d = wait_q;
      if (!in_tvalid[gi] || owns) wait_d = '0;
      else if (pkt_done)          wait_d = wait_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        wait_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        wait_q <= wait_d;
      end
    end

    assign pkt_count[gi*32 +: 32] = cnt_q;

    ast_no_starve: assert property (@(posedge clk) disable iff (!rst_n) wait_q <= STARVE_LIMIT);
  end
`endif

endmodule

// File: tb/tb_ase_emul_pcie_ss_tx_wrr_arb.sv
// Randomised bench for the WRR TX arbiter against a packet-level WRR reference model.
module tb_ase_emul_pcie_ss_tx_wrr_arb;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int UW  = 10;
  localparam int WW  = 4;
  localparam int KW  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } pl_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH*WW-1:0]   weights = '0;
  logic [NCH-1:0]      in_tvalid = '0;
  logic [NCH-1:0]      in_tready;
  logic [NCH-1:0]      in_tlast = '0;
  logic [NCH*DW-1:0]   in_tdata = '0;
  logic [NCH*KW-1:0]   in_tkeep = '0;
  logic [NCH*UW-1:0]   in_tuser_vendor = '0;
  logic                out_tvalid;
  logic                out_tready = 1'b1;
  logic                out_tlast;
  logic [DW-1:0]       out_tdata;
  logic [KW-1:0]       out_tkeep;
  logic [UW-1:0]       out_tuser_vendor;
  logic [0:0]          cur_grant;
`ifdef ASE_EMUL_TX_WRR_ARB_STATS_EN
  logic [NCH*32-1:0]   pkt_count;
`endif

  ase_emul_pcie_ss_tx_wrr_arb #(
    .NUM_CH(NCH), .DATA_W(DW), .USER_W(UW), .WEIGHT_W(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .weights(weights),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser_vendor(in_tuser_vendor),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser_vendor(out_tuser_vendor),
    .cur_grant(cur_grant)
`ifdef ASE_EMUL_TX_WRR_ARB_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sources, model inputs and collected output
  pl_t src_q[NCH][$];
  int  gap_q[NCH][$];
  pl_t model_q[NCH][$];
  pl_t exp_q[$];
  pl_t got_q[$];
  int  seq[NCH];
  int  tb_w[NCH];
  int  gap_left[NCH];
  logic [NCH-1:0] acc_n = '0;
  bit  stall_en = 1'b0;
  int  cyc = 0;
  int  first_cyc = -1;
  int  last_cyc = 0;
  bit  held_v = 1'b0;
  pl_t held;

  // Reference model state: round-robin pointer, turn owner, packets left in the turn
  int m_ptr = 0, m_owner = 0, m_credit = 0;

  always @(posedge clk) cyc++;

  // Source drivers: handshakes are sampled on the falling edge, inputs move 1 after the rising edge
  always @(negedge clk) acc_n = in_tvalid & in_tready;

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (acc_n[c] && src_q[c].size() > 0) begin
        void'(src_q[c].pop_front());
        void'(gap_q[c].pop_front());
        if (gap_q[c].size() > 0) gap_left[c] = gap_q[c][0];
      end
      if (src_q[c].size() > 0 && gap_left[c] == 0) begin
        in_tvalid[c] = 1'b1;
        {in_tdata[c*DW +: DW], in_tkeep[c*KW +: KW], in_tuser_vendor[c*UW +: UW], in_tlast[c]} = src_q[c][0];
      end else begin
        in_tvalid[c] = 1'b0;
        if (gap_left[c] > 0) gap_left[c]--;
      end
    end
    acc_n     = '0;
    out_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: stall stability and beat collection
  always @(negedge clk) begin
    pl_t cur;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      cur = {out_tdata, out_tkeep, out_tuser_vendor, out_tlast};
      if (held_v) begin
        chk("hold_valid", 128'(out_tvalid), 128'(1'b1));
        chk("hold_payload", 128'(cur), 128'(held));
      end
      held_v = out_tvalid && !out_tready;
      held   = cur;
      if (out_tvalid && out_tready) begin
        got_q.push_back(cur);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int ch_of(input pl_t p);
    return int'(p.data[DW-1 -: 8]);
  endfunction

  task automatic set_weights();
    for (int c = 0; c < NCH; c++) weights[c*WW +: WW] = WW'(tb_w[c]);
  endtask

  task automatic add_pkt(input int c, input int len, input int gap_at, input int gap_len);
    pl_t p;
    for (int b = 0; b < len; b++) begin
      p.data = {8'(c), 16'(seq[c]), 8'(b), 32'($urandom)};
      p.keep = KW'($urandom);
      p.user = UW'($urandom);
      p.last = (b == len - 1);
      src_q[c].push_back(p);
      gap_q[c].push_back((b == gap_at) ? gap_len : 0);
      model_q[c].push_back(p);
    end
    seq[c]++;
  endtask

  // Packet-level WRR: keep the owner while it has credit and a packet; else search from the pointer.
  task automatic model_run();
    int  w;
    bit  any;
    pl_t p;
    forever begin
      any = 1'b0;
      for (int c = 0; c < NCH; c++) if (model_q[c].size() > 0) any = 1'b1;
      if (!any) break;
      if (m_credit > 0 && model_q[m_owner].size() > 0) begin
        w = m_owner;
      end else begin
        w = -1;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (w < 0 && model_q[c].size() > 0) w = c;
        end
        m_owner  = w;
        m_credit = (tb_w[w] == 0) ? 1 : tb_w[w];
        m_ptr    = (w + 1) % NCH;
      end
      do begin
        p = model_q[w].pop_front();
        exp_q.push_back(p);
      end while (!p.last);
      m_credit--;
    end
  endtask

  task automatic run_phase(input string tag, input int budget, input bit span_chk, input int gap_total);
    int n, cy, bad;
    model_run();
    n  = exp_q.size();
    cy = 0;
    while (got_q.size() < n && cy < budget) begin
      @(posedge clk);
      cy++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(n));
    bad = -1;
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    end
    chk({tag, "_first_bad_beat"}, 128'(bad), 128'(-1));
    if (span_chk) chk({tag, "_span"}, 128'(last_cyc - first_cyc + 1), 128'(n + gap_total));
    $display("phase %s: %0d beats expected, %0d collected", tag, n, got_q.size());
  endtask

  task automatic clear_phase();
    got_q.delete();
    exp_q.delete();
    first_cyc = -1;
  endtask

  task automatic flush_all();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      gap_q[c].delete();
      model_q[c].delete();
      gap_left[c] = 0;
    end
    acc_n = '0;
    clear_phase();
    m_ptr = 0;
    m_owner = 0;
    m_credit = 0;
  endtask

  initial begin
    int total, cnt0, cnt1, bad, idx_last0, idx_first1;
    for (int c = 0; c < NCH; c++) begin
      seq[c] = 0;
      gap_left[c] = 0;
      tb_w[c] = 1;
    end
    set_weights();

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_tvalid", 128'(out_tvalid), 128'(0));
    chk("reset_in_tready", 128'(in_tready), 128'(0));
    chk("reset_cur_grant", 128'(cur_grant), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // Equal weights, 4-beat packets: alternation, latency and no bubbles
    tb_w[0] = 1; tb_w[1] = 1; set_weights();
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      add_pkt(0, 4, -1, 0);
      add_pkt(1, 4, -1, 0);
    end
    #2;
    chk("lat_req_presented", 128'(in_tvalid), 128'(2'b11));
    chk("lat_out_not_yet", 128'(out_tvalid), 128'(0));
    @(posedge clk);
    #2;
    chk("lat_out_valid", 128'(out_tvalid), 128'(1));
    chk("lat_first_beat", 128'(out_tdata), 128'(model_q[0][0].data));
    run_phase("alt", 200, 1'b1, 0);
    for (int p = 0; p < 4; p++) chk("alt_pkt_owner", 128'(ch_of(got_q[p*4])), 128'(p % 2));
    clear_phase();

    // Weights 3:1 with single-beat packets
    tb_w[0] = 3; tb_w[1] = 1; set_weights();
    @(posedge clk);
    for (int i = 0; i < 300; i++) add_pkt(0, 1, -1, 0);
    for (int i = 0; i < 100; i++) add_pkt(1, 1, -1, 0);
    run_phase("wrr31", 1000, 1'b1, 0);
    cnt0 = 0; cnt1 = 0; bad = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (ch_of(got_q[i]) == 0) cnt0++; else cnt1++;
      if (ch_of(got_q[i]) != ((i % 4 == 3) ? 1 : 0)) bad++;
    end
    chk("wrr31_ch0_pkts", 128'(cnt0), 128'(300));
    chk("wrr31_ch1_pkts", 128'(cnt1), 128'(100));
    chk("wrr31_pattern_errs", 128'(bad), 128'(0));
    clear_phase();

    // Mid-packet tvalid gap on the owner while the other channel waits
    tb_w[0] = 1; tb_w[1] = 1; set_weights();
    @(posedge clk);
    add_pkt(0, 5, 2, 2);
    add_pkt(1, 3, -1, 0);
    run_phase("gap", 100, 1'b1, 2);
    idx_last0 = -1; idx_first1 = -1;
    for (int i = 0; i < got_q.size(); i++) begin
      if (ch_of(got_q[i]) == 0 && got_q[i].last && idx_last0 < 0) idx_last0 = i;
      if (ch_of(got_q[i]) == 1 && idx_first1 < 0) idx_first1 = i;
    end
    chk("gap_ch0_tlast_idx", 128'(idx_last0), 128'(4));
    chk("gap_ch1_first_idx", 128'(idx_first1), 128'(5));
    clear_phase();

    // Random backpressure, lengths, gaps and weights over two weight settings
    for (int ph = 0; ph < 2; ph++) begin
      stall_en = 1'b1;
      tb_w[0] = $urandom_range(0, 15); tb_w[1] = $urandom_range(0, 15); set_weights();
      $display("stall phase %0d: weights ch0=%0d ch1=%0d", ph, tb_w[0], tb_w[1]);
      @(posedge clk);
      total = 0;
      while (total < 5000) begin
        int c, len, gat, glen;
        c   = $urandom_range(0, NCH - 1);
        len = $urandom_range(1, 6);
        gat = -1; glen = 0;
        if (len > 1 && $urandom_range(0, 3) == 0) begin
          gat  = $urandom_range(1, len - 1);
          glen = $urandom_range(1, 3);
        end
        add_pkt(c, len, gat, glen);
        total += len;
      end
      run_phase("stall", 40000, 1'b0, 0);
      stall_en = 1'b0;
      clear_phase();
    end

    // Asynchronous reset in the middle of a ch1 packet; first grant afterwards is ch0
    tb_w[0] = 1; tb_w[1] = 1; set_weights();
    @(posedge clk);
    add_pkt(1, 4, -1, 0);
    begin
      int cy;
      cy = 0;
      while (got_q.size() < 1 && cy < 50) begin
        @(posedge clk);
        cy++;
      end
    end
    chk("rst_pre_beat_seen", 128'(got_q.size() >= 1), 128'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush_all();
    #1;
    chk("rst_out_tvalid", 128'(out_tvalid), 128'(0));
    chk("rst_in_tready", 128'(in_tready), 128'(0));
    chk("rst_cur_grant", 128'(cur_grant), 128'(0));
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_in_tready", 128'(in_tready), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    add_pkt(1, 3, -1, 0);
    add_pkt(0, 3, -1, 0);
    run_phase("post_rst", 100, 1'b1, 0);
    chk("post_rst_first_owner", 128'(ch_of(got_q[0])), 128'(0));
    clear_phase();

`ifdef ASE_EMUL_TX_WRR_ARB_STATS_EN
    @(negedge clk) rst_n = 1'b0;
    flush_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) add_pkt(0, $urandom_range(1, 3), -1, 0);
    for (int i = 0; i < 3; i++) add_pkt(1, $urandom_range(1, 3), -1, 0);
    run_phase("stats", 200, 1'b1, 0);
    chk("stats_ch0", 128'(pkt_count[31:0]), 128'(7));
    chk("stats_ch1", 128'(pkt_count[63:32]), 128'(3));
    clear_phase();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
